// File: rtl/pipe_ctrl.sv
// pipe_ctrl: pipeline control unit for the five-stage core.
//
// Builds the per-stage hold vector from the IF/ID/MEM stall requests and
// sequences the PC redirect after an EX-stage taken branch. If an
// instruction fetch is still outstanding when the branch is accepted, the
// redirect waits until that fetch returns, and the fetch is flagged for
// discard in the meantime.
//
// Optional feature macro: PIPE_PERF_EN (adds saturating performance counters).
//
// Ports:
//   clk            in   single clock
//   rst            in   synchronous, active-high reset
//   if_stall_req   in   IF cannot accept/produce an instruction
//   id_stall_req   in   load-use hazard in ID
//   mem_stall_req  in   MEM access not complete
//   ex_b_flag_i    in   EX resolved a taken branch/jump this cycle
//   ex_b_target_i  in   branch target, valid with ex_b_flag_i
//   if_busy_i      in   instruction fetch outstanding
//   stall_state    out  per-stage hold vector [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB
//   pc_redirect_o  out  one-cycle pulse: PC loads pc_target_o
//   pc_target_o    out  registered redirect target
//   if_discard_o   out  returning fetch must be dropped
//   stall_cycles_o out  (PIPE_PERF_EN) cycles with stall_state != 0, saturating
//   flush_cnt_o    out  (PIPE_PERF_EN) accepted branches, saturating

module pipe_ctrl #(
  parameter int unsigned STALL_W = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_stall_req,
  input  logic               id_stall_req,
  input  logic               mem_stall_req,
  input  logic               ex_b_flag_i,
  input  logic [31:0]        ex_b_target_i,
  input  logic               if_busy_i,
  output logic [STALL_W-1:0] stall_state,
  output logic               pc_redirect_o,
  output logic [31:0]        pc_target_o,
  output logic               if_discard_o
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]        stall_cycles_o,
  output logic [31:0]        flush_cnt_o
`endif
);

  localparam logic [STALL_W-1:0] STALL_MEM  = STALL_W'(6'b011111);
  localparam logic [STALL_W-1:0] STALL_ID   = STALL_W'(6'b000111);
  localparam logic [STALL_W-1:0] STALL_IF   = STALL_W'(6'b000011);
  localparam logic [STALL_W-1:0] HOLD_PC_IF = STALL_W'(6'b000011);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WAIT_FETCH = 2'd1,
    REDIRECT   = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_target_q, pc_target_d;
  logic        accept;
  logic [STALL_W-1:0] base_stall;

  // Branch is taken up only from IDLE and only when MEM is not stalling;
  // under a MEM stall EX is held and the flag re-presents next cycle.
  assign accept = (state_q == IDLE) && ex_b_flag_i && !mem_stall_req;

  always_comb begin
    base_stall = '0;
    if (mem_stall_req) begin
      base_stall = STALL_MEM;
    end else if (id_stall_req && !accept) begin
      // The branch flush already removes the ID instruction, so a
      // load-use hazard in the accept cycle must not hold the pipe.
      base_stall = STALL_ID;
    end else if (if_stall_req) begin
      base_stall = STALL_IF;
    end
  end

  // PC and IF stay frozen from the accept until the redirect pulse.
  assign stall_state = base_stall | ((state_q != IDLE) ? HOLD_PC_IF : '0);

  always_comb begin
    state_d     = state_q;
    pc_target_d = pc_target_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          pc_target_d = ex_b_target_i;
          state_d     = if_busy_i ? WAIT_FETCH : REDIRECT;
        end
      end
      WAIT_FETCH: begin
        if (!if_busy_i) begin
          state_d = REDIRECT;
        end
      end
      REDIRECT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      pc_target_q <= pc_target_d;
    end
  end

  // Moore decodes of the state register: both clear together with reset.
  assign pc_redirect_o = (state_q == REDIRECT);
  assign if_discard_o  = (state_q == WAIT_FETCH);
  assign pc_target_o   = pc_target_q;

`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles_q, stall_cycles_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    flush_cnt_d    = flush_cnt_q;
    if ((|stall_state) && (stall_cycles_q != '1)) begin
      stall_cycles_d = stall_cycles_q + 32'd1;
    end
    if (accept && (flush_cnt_q != '1)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_cnt_q    <= '0;
    end else begin
      stall_cycles_q <= stall_cycles_d;
      flush_cnt_q    <= flush_cnt_d;
    end
  end

  assign stall_cycles_o = stall_cycles_q;
  assign flush_cnt_o    = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed self-checking bench for pipe_ctrl.
// Inputs change 1 time unit after the rising edge; outputs are checked
// before the next rising edge.

module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        if_stall_req;
  logic        id_stall_req;
  logic        mem_stall_req;
  logic        ex_b_flag_i;
  logic [31:0] ex_b_target_i;
  logic        if_busy_i;
  logic [5:0]  stall_state;
  logic        pc_redirect_o;
  logic [31:0] pc_target_o;
  logic        if_discard_o;
`ifdef PIPE_PERF_EN
  logic [31:0] stall_cycles_o;
  logic [31:0] flush_cnt_o;
`endif

  int unsigned n_checks;
  int unsigned n_errors;

  pipe_ctrl #(
    .STALL_W(6)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_stall_req  (if_stall_req),
    .id_stall_req  (id_stall_req),
    .mem_stall_req (mem_stall_req),
    .ex_b_flag_i   (ex_b_flag_i),
    .ex_b_target_i (ex_b_target_i),
    .if_busy_i     (if_busy_i),
    .stall_state   (stall_state),
    .pc_redirect_o (pc_redirect_o),
    .pc_target_o   (pc_target_o),
    .if_discard_o  (if_discard_o)
`ifdef PIPE_PERF_EN
    ,
    .stall_cycles_o(stall_cycles_o),
    .flush_cnt_o   (flush_cnt_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A taken-branch flag must only ever be presented while the unit is idle.
  always @(negedge clk) begin
    if (!rst) begin
      assert (!(ex_b_flag_i && (if_discard_o || pc_redirect_o)))
        else $error("branch flag presented outside IDLE");
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst           = 1'b1;
    if_stall_req  = 1'b0;
    id_stall_req  = 1'b0;
    mem_stall_req = 1'b1;
    ex_b_flag_i   = 1'b0;
    ex_b_target_i = '0;
    if_busy_i     = 1'b0;
    #1;
    check("rst_stall_comb", {26'd0, stall_state}, 32'h1F);
    tick();
    tick();
    check("rst_target",   pc_target_o, 32'h0);
    check("rst_redirect", {31'd0, pc_redirect_o}, 32'h0);
    check("rst_discard",  {31'd0, if_discard_o}, 32'h0);
    mem_stall_req = 1'b0;
    rst = 1'b0;
    tick();

    // Base stall priority in IDLE
    mem_stall_req = 1'b1; id_stall_req = 1'b1; #1;
    check("mem_id", {26'd0, stall_state}, 32'h1F);
    mem_stall_req = 1'b0; #1;
    check("id_only", {26'd0, stall_state}, 32'h07);
    id_stall_req = 1'b0; if_stall_req = 1'b1; #1;
    check("if_only", {26'd0, stall_state}, 32'h03);
    id_stall_req = 1'b1; #1;
    check("id_if", {26'd0, stall_state}, 32'h07);
    id_stall_req = 1'b0; if_stall_req = 1'b0; #1;
    check("none", {26'd0, stall_state}, 32'h00);
    tick();

    // Branch with idle fetch; ID request is ignored in the accept cycle
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h0000_1040; if_busy_i = 1'b0;
    id_stall_req = 1'b1; #1;
    check("acc_id_ignored", {26'd0, stall_state}, 32'h00);
    tick();
    ex_b_flag_i = 1'b0; ex_b_target_i = 32'hDEAD_BEEF; id_stall_req = 1'b0; #1;
    check("br_target",   pc_target_o, 32'h0000_1040);
    check("br_redirect", {31'd0, pc_redirect_o}, 32'h1);
    check("br_discard",  {31'd0, if_discard_o}, 32'h0);
    check("br_hold",     {26'd0, stall_state}, 32'h03);
    tick();
    check("br_pulse_end", {31'd0, pc_redirect_o}, 32'h0);
    check("br_stall_end", {26'd0, stall_state}, 32'h00);
    check("br_target_kept", pc_target_o, 32'h0000_1040);

    // Branch with a fetch outstanding for N..N+2
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h0000_2000; if_busy_i = 1'b1;
    tick();
    ex_b_flag_i = 1'b0; #1;                        // N+1
    check("wf1_discard", {31'd0, if_discard_o}, 32'h1);
    check("wf1_redirect", {31'd0, pc_redirect_o}, 32'h0);
    check("wf1_hold", {26'd0, stall_state}, 32'h03);
    check("wf1_target", pc_target_o, 32'h0000_2000);
    tick();                                        // N+2
    mem_stall_req = 1'b1; #1;
    check("wf2_discard", {31'd0, if_discard_o}, 32'h1);
    check("wf2_mem", {26'd0, stall_state}, 32'h1F);
    tick();                                        // N+3
    mem_stall_req = 1'b0; if_busy_i = 1'b0; #1;
    check("wf3_discard", {31'd0, if_discard_o}, 32'h1);
    check("wf3_redirect", {31'd0, pc_redirect_o}, 32'h0);
    tick();                                        // N+4
    check("wf4_redirect", {31'd0, pc_redirect_o}, 32'h1);
    check("wf4_discard", {31'd0, if_discard_o}, 32'h0);
    tick();                                        // N+5
    check("wf5_redirect", {31'd0, pc_redirect_o}, 32'h0);

    // Branch held off by a two-cycle MEM stall
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h0000_3000; mem_stall_req = 1'b1; #1;
    check("ms_stall", {26'd0, stall_state}, 32'h1F);
    tick();
    check("ms1_redirect", {31'd0, pc_redirect_o}, 32'h0);
    check("ms1_discard", {31'd0, if_discard_o}, 32'h0);
    check("ms1_target", pc_target_o, 32'h0000_2000);
    tick();
    check("ms2_redirect", {31'd0, pc_redirect_o}, 32'h0);
    check("ms2_target", pc_target_o, 32'h0000_2000);
    mem_stall_req = 1'b0;
    tick();
    ex_b_flag_i = 1'b0; #1;
    check("ms_acc_redirect", {31'd0, pc_redirect_o}, 32'h1);
    check("ms_acc_target", pc_target_o, 32'h0000_3000);
    tick();
    check("ms_pulse_end", {31'd0, pc_redirect_o}, 32'h0);

    // Reset while waiting for the fetch
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h0000_4000; if_busy_i = 1'b1;
    tick();
    ex_b_flag_i = 1'b0; #1;
    check("rw_discard_pre", {31'd0, if_discard_o}, 32'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("rw_discard", {31'd0, if_discard_o}, 32'h0);
    check("rw_target", pc_target_o, 32'h0);
    check("rw_redirect", {31'd0, pc_redirect_o}, 32'h0);
    if_busy_i = 1'b0;
    tick();
    check("rw_no_pulse1", {31'd0, pc_redirect_o}, 32'h0);
    tick();
    check("rw_no_pulse2", {31'd0, pc_redirect_o}, 32'h0);

`ifdef PIPE_PERF_EN
    // 5 IF-stalled cycles, a redirect (1 hold cycle), a branch waiting
    // one cycle on the fetch (2 hold cycles): 8 stall cycles, 2 flushes.
    rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    check("perf_rst_stall", stall_cycles_o, 32'd0);
    check("perf_rst_flush", flush_cnt_o, 32'd0);
    if_stall_req = 1'b1;
    for (int unsigned i = 0; i < 5; i++) tick();
    if_stall_req = 1'b0; #1;
    check("perf_stall5", stall_cycles_o, 32'd5);
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h0000_5000; if_busy_i = 1'b0;
    tick();
    ex_b_flag_i = 1'b0;
    tick();
    ex_b_flag_i = 1'b1; ex_b_target_i = 32'h0000_6000; if_busy_i = 1'b1;
    tick();
    ex_b_flag_i = 1'b0; if_busy_i = 1'b0;
    tick();
    tick();
    check("perf_stall_total", stall_cycles_o, 32'd8);
    check("perf_flush", flush_cnt_o, 32'd2);
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
